truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus driver and response collector for a combinational logic module with N_IN inputs and 1 output.
- Sits on the opposite side of the DUT's input/output pins. Walks every input vector 0..2^N_IN-1 and samples the DUT output into a truth-table register. Compares each sample against a golden table and reports pass/fail.
- Default golden table matches the team's 4-input function s = (b|c)&(a|~b|~c)&(~a|~b|d), with vec = {a,b,c,d} and a as MSB.

Parameters:
- N_IN, 4, number of DUT inputs; supported range 1..6.
- SETTLE, 1, extra wait cycles after each vector change before sampling; supported range 0..15.
- EXPECTED, 16'hAC3C, golden table, width 2^N_IN; bit i is the expected output for input vector i.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  begins a sweep; sampled only in IDLE.
- s_in  input  1  DUT output under test.
- vec_out  output  N_IN  vector currently driven to the DUT inputs; registered.
- busy  output  1  high from the cycle after start is accepted until the last sample.
- done  output  1  one-cycle pulse after the final sample.
- table_out  output  2^N_IN  captured truth table; bit i is s_in sampled under vector i.
- pass  output  1  valid when done=1 or in IDLE after a sweep; 1 iff table_out == EXPECTED.
- mismatch_cnt  output  N_IN+1  number of mismatching vectors in the last sweep.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, vec_out=0, busy=0, done=0, table_out=0, pass=0, mismatch_cnt=0, settle counter=0.
  - Reset mid-sweep aborts immediately; no partial results are retained.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If start=1: vec_out<=0, cnt<=SETTLE, table_out<=0, mismatch_cnt<=0, pass<=0, busy<=1, then go to WAIT.
  - Otherwise hold all outputs; results from the previous sweep remain visible.
- WAIT, when cnt!=0: cnt<=cnt-1.
- WAIT, when cnt==0 (sample edge):
  - table_out[vec_out]<=s_in.
  - If s_in!=EXPECTED[vec_out]: mismatch_cnt<=mismatch_cnt+1.
  - If vec_out==2^N_IN-1: go to DONE, busy<=0.
  - Otherwise vec_out<=vec_out+1, cnt<=SETTLE.
- Timing per vector:
  - SETTLE+1 cycles per vector. With SETTLE=0, s_in is sampled one edge after vec_out changes (one full cycle of combinational settle).
  - Total sweep is 2^N_IN*(SETTLE+1) cycles from the start-accept edge to the last sample edge.
- DONE:
  - done=1 for exactly one cycle.
  - pass=(mismatch_cnt==0), computed from the final count including the last sample.
  - Next state is IDLE.
- vec_out holds the last vector (2^N_IN-1) after the sweep and is cleared only by the next start or by reset.
- start while busy or in DONE is ignored; there is no queuing. start held high in IDLE after DONE launches a new sweep.
- The counter does not wrap: vec_out never advances past 2^N_IN-1.
- mismatch_cnt saturation is not needed: its width covers 2^N_IN.

Optional Feature:
- Macro: SWEEP_ABORT_EN.
- When defined:
  - Adds output first_fail (N_IN bits) and output aborted (1 bit).
  - On the first mismatch, first_fail<=vec_out, aborted<=1, mismatch_cnt=1, and the FSM goes directly to DONE. done pulses and pass=0.
  - Unvisited table_out bits stay 0.
  - first_fail and aborted reset to 0 and are cleared on start.
- When undefined: full sweep always; no extra ports.

Test Plan:
- Golden DUT (s = (b|c)&(a|~b|~c)&(~a|~b|d) connected to vec_out), SETTLE=1, pulse start:
  - done after 32 cycles.
  - table_out=16'hAC3C, pass=1, mismatch_cnt=0.
- Faulty DUT stuck-at-0, SETTLE=0:
  - Sweep takes 16 cycles.
  - table_out=16'h0000, mismatch_cnt=8, pass=0.
- DUT outputs inverted golden:
  - table_out=16'h53C3, mismatch_cnt=16, pass=0.
- rst asserted at vec_out=7 mid-sweep:
  - Outputs zero immediately (asynchronously).
  - A new start gives a clean full sweep with pass=1.
- start pulsed again at vec_out=5 and during DONE:
  - Ignored; exactly one done pulse; vec_out advances monotonically 0..15.
- With SWEEP_ABORT_EN, DUT correct except vector 6 forced to 1:
  - Abort at vector 6: first_fail=6, aborted=1, mismatch_cnt=1.
  - table_out=16'h007C (bits 2..6), done after 7*(SETTLE+1) cycles.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of an N_IN-input combinational block, captures its
// response into a truth table and compares it against EXPECTED. Optional macro: SWEEP_ABORT_EN.
module truth_table_sweeper #(
  parameter int                      N_IN     = 4,
  parameter int                      SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = 16'hAC3C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       s_in,
  output logic [N_IN-1:0]            vec_out,
  output logic                       busy,
  output logic                       done,
  output logic [(1<<N_IN)-1:0]       table_out,
  output logic                       pass,
  output logic [N_IN:0]              mismatch_cnt
`ifdef SWEEP_ABORT_EN
  ,
  output logic [N_IN-1:0]            first_fail,
  output logic                       aborted
`endif
);

  localparam int NV = 1 << N_IN;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NV-1:0]     tbl_q, tbl_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     mm_q, mm_d;
  logic              mis_s;
  logic              abort_s;
`ifdef SWEEP_ABORT_EN
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              ab_q, ab_d;
`endif

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= '0;
      pass_q  <= 1'b0;
      mm_q    <= '0;
`ifdef SWEEP_ABORT_EN
      ff_q    <= '0;
      ab_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
`ifdef SWEEP_ABORT_EN
      ff_q    <= ff_d;
      ab_q    <= ab_d;
`endif
    end
  end

  // Next-state and result update logic.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tbl_d   = tbl_q;
    pass_d  = pass_q;
    mm_d    = mm_q;
`ifdef SWEEP_ABORT_EN
    ff_d    = ff_q;
    ab_d    = ab_q;
`endif
    mis_s   = (s_in != EXPECTED[vec_q]);
`ifdef SWEEP_ABORT_EN
    abort_s = mis_s;
`else
    abort_s = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          vec_d   = '0;
          cnt_d   = SETTLE_C;
          tbl_d   = '0;
          mm_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef SWEEP_ABORT_EN
          ff_d    = '0;
          ab_d    = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          tbl_d[vec_q] = s_in;
          if (mis_s) begin
            mm_d = mm_q + (N_IN+1)'(1);
          end else begin
            mm_d = mm_q;
          end
          // done is registered on the final sample edge so it is high exactly during DONE.
          if (abort_s) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
`ifdef SWEEP_ABORT_EN
            ff_d    = vec_q;
            ab_d    = 1'b1;
`endif
          end else if (&vec_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mm_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = SETTLE_C;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign vec_out      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = tbl_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mm_q;
`ifdef SWEEP_ABORT_EN
  assign first_fail   = ff_q;
  assign aborted      = ab_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (SETTLE=1 and SETTLE=0) driven against a
// table-based DUT response, checked against a vector-by-vector reference model.
module tb_truth_table_sweeper;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        start_w;
  logic [1:0]        sin_w;
  logic [1:0][3:0]   vec_w;
  logic [1:0]        busy_w;
  logic [1:0]        done_w;
  logic [1:0][15:0]  tbl_w;
  logic [1:0]        pass_w;
  logic [1:0][4:0]   mm_w;
`ifdef SWEEP_ABORT_EN
  logic [1:0][3:0]   ff_w;
  logic [1:0]        ab_w;
`endif
  logic [15:0]       resp_tbl;
  logic [15:0]       golden_tbl;
  int                n_vec = 0;
  int                n_mis = 0;

  always #5 clk = ~clk;

  always_comb sin_w = {resp_tbl[vec_w[1]], resp_tbl[vec_w[0]]};

  truth_table_sweeper #(.N_IN(4), .SETTLE(1), .EXPECTED(16'hAC3C)) u_s1 (
    .clk(clk), .rst(rst), .start(start_w[0]), .s_in(sin_w[0]),
    .vec_out(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .table_out(tbl_w[0]), .pass(pass_w[0]), .mismatch_cnt(mm_w[0])
`ifdef SWEEP_ABORT_EN
    , .first_fail(ff_w[0]), .aborted(ab_w[0])
`endif
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(0), .EXPECTED(16'hAC3C)) u_s0 (
    .clk(clk), .rst(rst), .start(start_w[1]), .s_in(sin_w[1]),
    .vec_out(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .table_out(tbl_w[1]), .pass(pass_w[1]), .mismatch_cnt(mm_w[1])
`ifdef SWEEP_ABORT_EN
    , .first_fail(ff_w[1]), .aborted(ab_w[1])
`endif
  );

  function automatic logic golden_bit(input int v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return (b | c) & (a | ~b | ~c) & (~a | ~b | d);
  endfunction

  // Reference: visit vectors in order, stop at first mismatch when aborting is built in.
  function automatic void model(input logic [15:0] resp, input int settle,
                                output logic [15:0] tbl, output int mm, output bit ps,
                                output int cyc, output int last, output int ff, output bit ab);
    bit stop;
    tbl = 16'h0000; mm = 0; cyc = 0; last = 0; ff = 0; ab = 1'b0; stop = 1'b0;
    for (int v = 0; v < 16; v++) begin
      if (!stop) begin
        tbl[v] = resp[v];
        cyc += settle + 1;
        last = v;
        if (resp[v] != golden_bit(v)) begin
          mm++;
`ifdef SWEEP_ABORT_EN
          ab = 1'b1; ff = v; stop = 1'b1;
`endif
        end
      end
    end
    ps = (mm == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input int idx, input logic [15:0] resp, input bit poke);
    logic [15:0] e_tbl;
    int          e_mm, e_cyc, e_last, e_ff, cyc, settle;
    bit          e_pass, e_ab, mono, poked;
    logic [3:0]  prev;
    settle   = (idx == 0) ? 1 : 0;
    resp_tbl = resp;
    model(resp, settle, e_tbl, e_mm, e_pass, e_cyc, e_last, e_ff, e_ab);
    @(negedge clk);
    start_w[idx] = 1'b1;
    @(posedge clk); #1;
    start_w[idx] = 1'b0;
    chk("busy_after_start", {31'd0, busy_w[idx]}, 32'd1);
    chk("vec_at_start", {28'd0, vec_w[idx]}, 32'd0);
    cyc = 0; mono = 1'b1; poked = 1'b0; prev = 4'd0;
    while (done_w[idx] !== 1'b1 && cyc < 200) begin
      if (poke && !poked && vec_w[idx] == 4'd5) begin
        start_w[idx] = 1'b1;
        poked = 1'b1;
      end
      @(posedge clk); #1;
      start_w[idx] = 1'b0;
      cyc++;
      if (!(vec_w[idx] == prev || vec_w[idx] == prev + 4'd1)) mono = 1'b0;
      prev = vec_w[idx];
    end
    chk("sweep_cycles", cyc, e_cyc);
    chk("table_out", {16'd0, tbl_w[idx]}, {16'd0, e_tbl});
    chk("mismatch_cnt", {27'd0, mm_w[idx]}, e_mm);
    chk("pass_at_done", {31'd0, pass_w[idx]}, {31'd0, e_pass});
    chk("busy_at_done", {31'd0, busy_w[idx]}, 32'd0);
    chk("vec_monotonic", {31'd0, mono}, 32'd1);
`ifdef SWEEP_ABORT_EN
    chk("first_fail", {28'd0, ff_w[idx]}, e_ff);
    chk("aborted", {31'd0, ab_w[idx]}, {31'd0, e_ab});
`endif
    if (poke) start_w[idx] = 1'b1;
    @(posedge clk); #1;
    start_w[idx] = 1'b0;
    chk("done_one_cycle", {31'd0, done_w[idx]}, 32'd0);
    chk("idle_not_busy", {31'd0, busy_w[idx]}, 32'd0);
    chk("vec_held", {28'd0, vec_w[idx]}, e_last);
    chk("pass_held", {31'd0, pass_w[idx]}, {31'd0, e_pass});
    @(posedge clk); #1;
    chk("still_idle", {31'd0, busy_w[idx] | done_w[idx]}, 32'd0);
  endtask

  initial begin
    int waited;
    logic [15:0] r;
    rst = 1'b1;
    start_w = 2'b00;
    resp_tbl = 16'h0000;
    for (int v = 0; v < 16; v++) golden_tbl[v] = golden_bit(v);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_vec", {28'd0, vec_w[i]}, 32'd0);
      chk("rst_busy_done_pass", {29'd0, busy_w[i], done_w[i], pass_w[i]}, 32'd0);
      chk("rst_table", {16'd0, tbl_w[i]}, 32'd0);
      chk("rst_mm", {27'd0, mm_w[i]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, golden_tbl, 1'b0);
    chk("golden_table_const", {16'd0, tbl_w[0]}, 32'h0000AC3C);
    run_sweep(1, 16'h0000, 1'b0);
    run_sweep(0, ~golden_tbl, 1'b0);

    // Mid-sweep reset at vector 7, then a clean sweep.
    resp_tbl = golden_tbl;
    @(negedge clk);
    start_w[0] = 1'b1;
    @(posedge clk); #1;
    start_w[0] = 1'b0;
    waited = 0;
    while (vec_w[0] != 4'd7 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("reached_vec7", {28'd0, vec_w[0]}, 32'd7);
    rst = 1'b1;
    #1;
    chk("async_rst_vec", {28'd0, vec_w[0]}, 32'd0);
    chk("async_rst_flags", {29'd0, busy_w[0], done_w[0], pass_w[0]}, 32'd0);
    chk("async_rst_table", {16'd0, tbl_w[0]}, 32'd0);
    chk("async_rst_mm", {27'd0, mm_w[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, golden_tbl, 1'b0);

    run_sweep(0, golden_tbl, 1'b1);
    run_sweep(0, golden_tbl | 16'h0040, 1'b0);
    run_sweep(1, golden_tbl | 16'h0040, 1'b0);

    for (int k = 0; k < 6; k++) begin
      r = 16'($urandom);
      run_sweep(k % 2, r, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
